// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel coordinates, active-video flag, syncs, line/frame strobes
// and a wrapping frame counter. All outputs are registers and move together with x/y.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixel_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END    = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic       SYNC_ON      = (SYNC_POL != 0);

    logic [9:0] x_q, x_d, y_q, y_d;
    logic       active_q, active_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic [7:0] frame_count_q, frame_count_d;

    logic       x_wrap, y_wrap;
    logic [9:0] x_nxt, y_nxt;

    always_comb begin
        x_wrap = (x_q == H_LAST);
        y_wrap = (y_q == V_LAST);
        x_nxt  = x_wrap ? 10'd0 : x_q + 10'd1;
        if (x_wrap) begin
            y_nxt = y_wrap ? 10'd0 : y_q + 10'd1;
        end else begin
            y_nxt = y_q;
        end
    end

    // Decoded flags are computed from the next coordinates so they land on the
    // same edge as x/y and never lag them.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        active_d      = active_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_count_d = frame_count_q;
        if (pixel_en) begin
            x_d      = x_nxt;
            y_d      = y_nxt;
            active_d = (x_nxt < H_ACT_END) && (y_nxt < V_ACT_END);
            hsync_d  = ((x_nxt >= H_SYNC_START) && (x_nxt < H_SYNC_END)) ? SYNC_ON : ~SYNC_ON;
            vsync_d  = ((y_nxt >= V_SYNC_START) && (y_nxt < V_SYNC_END)) ? SYNC_ON : ~SYNC_ON;
            line_start_d  = x_wrap;
            frame_start_d = x_wrap && y_wrap;
            if (x_wrap && y_wrap) begin
                frame_count_d = frame_count_q + 8'd1;
            end
        end
    end

    // Reset parks the raster on its last pixel so the first enabled edge is a frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            active_q      <= 1'b0;
            hsync_q       <= ~SYNC_ON;
            vsync_q       <= ~SYNC_ON;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign active      = active_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule
